muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN SHALL be: XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 Port CLK SHALL be: CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port RESET_N SHALL be: RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 Port IN_VALID SHALL be: IN_VALID  input  1  operands/op presented.
REQ-005 Port IN_READY SHALL be: IN_READY  output  1  unit can accept an op.
REQ-006 Port SELECT SHALL be: SELECT  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Ports DATA1 and DATA2 SHALL be: DATA1/DATA2  input  XLEN  rs1/rs2 operands.
REQ-008 Port FLUSH SHALL be: FLUSH  input  1  pipeline kill; abort current op.
REQ-009 Port OUT_VALID SHALL be: OUT_VALID  output  1  RESULT valid.
REQ-010 Port OUT_READY SHALL be: OUT_READY  input  1  consumer takes RESULT.
REQ-011 Port RESULT SHALL be: RESULT  output  XLEN  registered result.
REQ-012 Port ZERO SHALL be: ZERO  output  1  RESULT == 0, valid with OUT_VALID.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE; IN_READY SHALL be 1 only in IDLE.
REQ-014 When IN_VALID&&IN_READY at an edge, the unit SHALL latch SELECT/DATA1/DATA2 and go to CALC, or to DONE for a special case.
REQ-015 CALC SHALL last exactly XLEN cycles (one iteration per cycle: shift-add multiply, restoring divide on magnitudes); OUT_VALID SHALL rise XLEN+1 edges after acceptance.
REQ-016 Signed ops SHALL operate on magnitudes, and the sign SHALL be fixed at the end: quotient negated if operand signs differ, remainder takes the dividend's sign, and the product is negated per the MULH/MULHSU sign rules.
REQ-017 MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-018 Divide by zero SHALL go directly to DONE, with latency 1: quotient = all ones, remainder = DATA1.
REQ-019 Signed overflow (DATA1 = most negative, DATA2 = -1, DIV/REM) SHALL go directly to DONE, with latency 1: quotient = DATA1, remainder = 0.
REQ-020 In DONE, OUT_VALID and RESULT SHALL be held stable until OUT_READY; on the OUT_READY edge the unit SHALL go to IDLE, with OUT_VALID=0 the next cycle (no same-cycle re-accept).
REQ-021 FLUSH in any state SHALL force IDLE at the next edge and drop OUT_VALID; FLUSH SHALL win over a simultaneous accept or OUT_READY; RESULT SHALL be left unchanged.
REQ-022 IN_VALID SHALL be ignored outside IDLE; operand changes after acceptance SHALL have no effect.

Reset
REQ-023 RESET_N low SHALL immediately force: state IDLE, IN_READY=1, OUT_VALID=0, RESULT=0, ZERO=1, iteration counter 0.
REQ-024 Reset mid-CALC or in DONE SHALL discard the op; the first accept after release SHALL behave as from power-up.

Configuration
REQ-025 The macro MULDIV_FAST_MUL_EN SHALL control the multiply path.
REQ-026 With MULDIV_FAST_MUL_EN defined, MUL/MULH/MULHSU/MULHU SHALL use a single-cycle full-width multiplier and go IDLE->DONE with latency 1, while divides are unchanged.
REQ-027 Without MULDIV_FAST_MUL_EN, all multiplies SHALL be iterative per REQ-015, and no XLEN x XLEN multiplier SHALL be inferred.

Structure
REQ-028 Package muldiv_pkg SHALL hold the funct3 op constants, the FSM state enum, and the helper is_div/is_signed decode functions.
REQ-029 The iterative restoring divider SHALL be sub-module div_iter (start, XLEN-cycle step, quotient/remainder magnitudes); multiply, sign fix and FSM SHALL stay in muldiv_unit.

Verification (XLEN=32, default build unless stated)
REQ-030 MUL 7 x 0xFFFFFFFD: RESULT SHALL be 0xFFFFFFEB, with OUT_VALID 33 edges after acceptance.
REQ-031 MULH 0x80000000 x 0x80000000 SHALL give 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFE; with MULDIV_FAST_MUL_EN the same values SHALL arrive 1 edge after acceptance.
REQ-032 DIV 0xFFFFFFF9 / 2 SHALL give 0xFFFFFFFD; REM of the same SHALL give 0xFFFFFFFF; DIVU 6 / 3 SHALL give 2 with ZERO=0; REMU 6 / 3 SHALL give 0 with ZERO=1.
REQ-033 DIVU 5 / 0 SHALL give 0xFFFFFFFF and REMU 5 / 0 SHALL give 5; DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000 and REM SHALL give 0; each SHALL complete with 1-cycle latency.
REQ-034 Hold OUT_READY=0 for 5 cycles in DONE: RESULT/OUT_VALID SHALL stay stable and IN_READY SHALL stay 0 with IN_VALID pulsed; after OUT_READY, IN_READY SHALL be 1 the next cycle.
REQ-035 FLUSH at CALC cycle 10, and RESET_N low at CALC cycle 20 on a separate op: IDLE SHALL be reached with OUT_VALID never asserted, and a following DIVU 100 / 7 SHALL give 14.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M-style multiply/divide unit:
//   - funct3 operation codes (SELECT encoding)
//   - FSM state enumeration
//   - decode helpers: is_div, is_signed (rs1 signedness), is_signed_rs2
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // All divide/remainder ops have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as a signed operand.
  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as a signed operand (MULHSU keeps rs2 unsigned).
  function automatic logic is_signed_rs2(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Request/response bundle of the multiply/divide unit.
//   IN_VALID / IN_READY   : op handshake (SELECT, DATA1, DATA2 qualify it)
//   FLUSH                 : abort the current op
//   OUT_VALID / OUT_READY : result handshake (RESULT, ZERO qualify it)
// Modports: slave = the unit, master = the requester.
// ---------------------------------------------------------------------------
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [2:0]      SELECT;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic            FLUSH;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] RESULT;
  logic            ZERO;

  modport slave (
    input  IN_VALID, SELECT, DATA1, DATA2, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, RESULT, ZERO
  );

  modport master (
    output IN_VALID, SELECT, DATA1, DATA2, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, RESULT, ZERO
  );
endinterface

// File: rtl/muldiv_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// step. i_start loads the operands; each i_step retires one bit, so XLEN
// steps produce the full quotient/remainder.
// The outputs are the quotient/remainder *after* the step being taken this
// cycle, so the caller can capture the final values on the last step edge.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_start                 : load i_dividend / i_divisor (wins over i_step)
//   i_step                  : perform one iteration
//   o_quo_nxt, o_rem_nxt    : magnitudes after the current step
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quo_nxt,
  output logic [XLEN-1:0] o_rem_nxt
);

  logic [XLEN-1:0] r_q;   // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0] r_r;   // partial remainder, always < divisor
  logic [XLEN-1:0] r_d;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  // Partial remainder is < divisor, so the trial fits in XLEN+1 bits and the
  // borrow (MSB of the difference) tells whether the subtraction restores.
  assign w_trial   = {r_r, r_q[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, r_d};
  assign w_ge      = ~w_diff[XLEN];
  assign o_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
  assign o_quo_nxt = {r_q[XLEN-2:0], w_ge};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
      r_r <= '0;
      r_d <= '0;
    end else if (i_start) begin
      r_q <= i_dividend;
      r_r <= '0;
      r_d <= i_divisor;
    end else if (i_step) begin
      r_q <= o_quo_nxt;
      r_r <= o_rem_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// RV32M multiply/divide unit. Operands are converted to magnitudes on
// acceptance, processed iteratively (shift-add multiply here, restoring
// divide in div_iter) for XLEN cycles, and the sign is applied when the
// final result is registered.
// Divide-by-zero and signed overflow complete directly (IDLE->DONE).
// Build option: define MULDIV_FAST_MUL_EN to complete all multiplies in a
// single cycle through a full-width multiplier; divides are unaffected.
// Ports:
//   CLK      : clock
//   RESET_N  : asynchronous active-low reset
//   bus      : muldiv_if.slave (IN_VALID/IN_READY, SELECT, DATA1, DATA2,
//              FLUSH, OUT_VALID/OUT_READY, RESULT, ZERO)
// ---------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    CLK,
  input  logic    RESET_N,
  muldiv_if.slave bus
);

  localparam int            CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_result;
  logic            r_neg;       // negate product / quotient
  logic            r_rem_neg;   // remainder follows the dividend sign

  logic            w_accept;
  logic            w_last;
  logic            w_s1;
  logic            w_s2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast_mul;
  logic            w_direct;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN-1:0] w_direct_res;
  logic [XLEN-1:0] w_final;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;
  logic [XLEN-1:0] w_quo_mag;
  logic [XLEN-1:0] w_rem_mag;

  // Apply the sign to a magnitude result and pick the half/field the op wants.
  function automatic logic [XLEN-1:0] fix_sign(
    input logic [2:0]        op,
    input logic [2*XLEN-1:0] prod_mag,
    input logic [XLEN-1:0]   quo_mag,
    input logic [XLEN-1:0]   rem_mag,
    input logic              neg,
    input logic              rem_neg
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;
    prod = neg ? -prod_mag : prod_mag;
    case (op)
      OP_MUL:                      res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             res = neg ? -quo_mag : quo_mag;
      default:                     res = rem_neg ? -rem_mag : rem_mag;
    endcase
    return res;
  endfunction

  // ---- acceptance decode (IDLE) -------------------------------------------
  assign w_accept = bus.IN_VALID && (r_state == ST_IDLE) && !bus.FLUSH;
  assign w_s1     = is_signed(bus.SELECT) && bus.DATA1[XLEN-1];
  assign w_s2     = is_signed_rs2(bus.SELECT) && bus.DATA2[XLEN-1];
  assign w_mag1   = w_s1 ? -bus.DATA1 : bus.DATA1;
  assign w_mag2   = w_s2 ? -bus.DATA2 : bus.DATA2;
  assign w_div0   = is_div(bus.SELECT) && (bus.DATA2 == '0);
  assign w_ovf    = is_div(bus.SELECT) && is_signed(bus.SELECT) &&
                    (bus.DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.DATA2);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
  assign w_fast_mul  = !is_div(bus.SELECT);
`else
  assign w_fast_mul  = 1'b0;
`endif

  assign w_direct = w_div0 || w_ovf || w_fast_mul;

  always_comb begin
    w_direct_res = '0;
    if (w_div0) begin
      w_direct_res = bus.SELECT[1] ? bus.DATA1 : '1;
    end else if (w_ovf) begin
      w_direct_res = bus.SELECT[1] ? '0 : bus.DATA1;
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      w_direct_res = fix_sign(bus.SELECT, w_fast_prod, '0, '0, w_s1 ^ w_s2, 1'b0);
    end
`endif
  end

  // ---- iteration (CALC) -----------------------------------------------------
  // Shift-add multiply: {carry, hi, lo} shifts right one bit per step while
  // the multiplier in lo is consumed LSB first.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign w_hi_nxt = w_sum[XLEN:1];
  assign w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
  assign w_last   = (r_state == ST_CALC) && (r_cnt == LAST_CNT);

  div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_start    (w_accept),
    .i_step     ((r_state == ST_CALC) && !bus.FLUSH),
    .i_dividend (w_mag1),
    .i_divisor  (w_mag2),
    .o_quo_nxt  (w_quo_mag),
    .o_rem_nxt  (w_rem_mag)
  );

  assign w_final = fix_sign(r_op, {w_hi_nxt, w_lo_nxt}, w_quo_mag, w_rem_mag,
                            r_neg, r_rem_neg);

  // ---- FSM ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.FLUSH) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.IN_VALID)  w_state_nxt = w_direct ? ST_DONE : ST_CALC;
        ST_CALC: if (w_last)        w_state_nxt = ST_DONE;
        ST_DONE: if (bus.OUT_READY) w_state_nxt = ST_IDLE;
        default:                    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---- datapath registers -------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_op      <= '0;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_op      <= bus.SELECT;
      r_cnt     <= '0;
      r_mcand   <= w_mag1;
      r_hi      <= '0;
      r_lo      <= w_mag2;
      r_neg     <= w_s1 ^ w_s2;
      r_rem_neg <= w_s1;
      if (w_direct) r_result <= w_direct_res;
    end else if (r_state == ST_CALC) begin
      if (bus.FLUSH) begin
        r_cnt <= '0;
      end else begin
        r_hi <= w_hi_nxt;
        r_lo <= w_lo_nxt;
        if (w_last) begin
          r_result <= w_final;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.IN_READY  = (r_state == ST_IDLE);
  assign bus.OUT_VALID = (r_state == ST_DONE);
  assign bus.RESULT    = r_result;
  assign bus.ZERO      = (r_result == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;
  localparam int SPC_LAT = 1;

  logic CLK;
  logic RESET_N;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!bus.IN_READY && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
    end
    bus.SELECT   = sel;
    bus.DATA1    = a;
    bus.DATA2    = b;
    bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    // Accept edge was edge 1; operands scrambled afterwards must not matter.
    bus.IN_VALID = 1'b0;
    bus.DATA1    = ~a;
    bus.DATA2    = a ^ b ^ 32'h5A5A_1234;
    bus.SELECT   = ~sel;
    lat = 1;
    while (!bus.OUT_VALID && lat < 80) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({nm, "_lat"},  64'(lat), 64'(exp_lat));
    chk({nm, "_res"},  64'(bus.RESULT), 64'(exp_res));
    chk({nm, "_zero"}, 64'(bus.ZERO), 64'(exp_zero));
    bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    bus.OUT_READY = 1'b0;
    chk({nm, "_idle"}, 64'({bus.IN_READY, bus.OUT_VALID}), 64'(2'b10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;

    vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, MUL_LAT};
    vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, MUL_LAT};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_LAT};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, MUL_LAT};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, DIV_LAT};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, DIV_LAT};
    vecs[6]  = '{OP_DIVU,   32'h0000_0006, 32'h0000_0003, 32'h0000_0002, 1'b0, DIV_LAT};
    vecs[7]  = '{OP_REMU,   32'h0000_0006, 32'h0000_0003, 32'h0000_0000, 1'b1, DIV_LAT};
    vecs[8]  = '{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, SPC_LAT};
    vecs[9]  = '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, SPC_LAT};
    vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, SPC_LAT};
    vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, SPC_LAT};
    vecs[12] = '{OP_DIV,    32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, SPC_LAT};
    vecs[13] = '{OP_MUL,    32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 1'b1, MUL_LAT};
    vecs[14] = '{OP_DIV,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, DIV_LAT};
    vecs[15] = '{OP_REM,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, DIV_LAT};

    bus.IN_VALID  = 1'b0;
    bus.SELECT    = 3'b000;
    bus.DATA1     = '0;
    bus.DATA2     = '0;
    bus.FLUSH     = 1'b0;
    bus.OUT_READY = 1'b0;
    RESET_N       = 1'b1;

    // Asynchronous reset, observed before any clock edge.
    #2 RESET_N = 1'b0;
    #1;
    chk("reset_in_ready",  64'(bus.IN_READY), 64'(1));
    chk("reset_out_valid", 64'(bus.OUT_VALID), 64'(0));
    chk("reset_result",    64'(bus.RESULT), 64'(0));
    chk("reset_zero",      64'(bus.ZERO), 64'(1));
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].zero, vecs[i].lat);
    end

    // Hold in DONE with OUT_READY low while IN_VALID is presented.
    bus.SELECT = OP_DIVU; bus.DATA1 = 32'd5; bus.DATA2 = 32'd0; bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    chk("hold_enter", 64'(bus.OUT_VALID), 64'(1));
    for (int k = 0; k < 5; k++) begin
      bus.IN_VALID = 1'b1; bus.SELECT = OP_MUL; bus.DATA1 = 32'd3; bus.DATA2 = 32'd3;
      @(posedge CLK); #1;
      chk($sformatf("hold_flags%0d", k), 64'({bus.OUT_VALID, bus.IN_READY}), 64'(2'b10));
      chk($sformatf("hold_res%0d", k), 64'(bus.RESULT), 64'(32'hFFFF_FFFF));
    end
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    bus.OUT_READY = 1'b0;
    chk("hold_release", 64'({bus.IN_READY, bus.OUT_VALID}), 64'(2'b10));
    @(posedge CLK); #1;
    chk("hold_still_idle", 64'(bus.IN_READY), 64'(1));

    // FLUSH beats a simultaneous accept.
    bus.SELECT = OP_DIVU; bus.DATA1 = 32'd6; bus.DATA2 = 32'd3;
    bus.IN_VALID = 1'b1; bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0; bus.FLUSH = 1'b0;
    chk("flush_accept", 64'({bus.IN_READY, bus.OUT_VALID}), 64'(2'b10));

    // FLUSH at CALC cycle 10.
    saw_valid = 1'b0;
    bus.SELECT = OP_DIVU; bus.DATA1 = 32'd1000; bus.DATA2 = 32'd3; bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    chk("flush_in_calc", 64'(bus.IN_READY), 64'(0));
    repeat (9) begin
      @(posedge CLK); #1;
      if (bus.OUT_VALID) saw_valid = 1'b1;
    end
    bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    chk("flush_idle", 64'({bus.IN_READY, bus.OUT_VALID}), 64'(2'b10));
    chk("flush_result_kept", 64'(bus.RESULT), 64'(32'hFFFF_FFFF));
    repeat (40) begin
      @(posedge CLK); #1;
      if (bus.OUT_VALID) saw_valid = 1'b1;
    end
    chk("flush_never_valid", 64'(saw_valid), 64'(0));

    // FLUSH in DONE drops OUT_VALID, leaves RESULT.
    bus.SELECT = OP_DIV; bus.DATA1 = 32'h8000_0000; bus.DATA2 = 32'hFFFF_FFFF;
    bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0; bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    chk("flush_done", 64'({bus.IN_READY, bus.OUT_VALID}), 64'(2'b10));
    chk("flush_done_res", 64'(bus.RESULT), 64'(32'h8000_0000));

    // RESET_N low at CALC cycle 20.
    saw_valid = 1'b0;
    bus.SELECT = OP_DIVU; bus.DATA1 = 32'hFFFF_FFFF; bus.DATA2 = 32'd3; bus.IN_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    repeat (19) begin
      @(posedge CLK); #1;
      if (bus.OUT_VALID) saw_valid = 1'b1;
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_calc_flags", 64'({bus.IN_READY, bus.OUT_VALID, bus.ZERO}), 64'(3'b101));
    chk("rst_calc_result", 64'(bus.RESULT), 64'(0));
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (40) begin
      @(posedge CLK); #1;
      if (bus.OUT_VALID) saw_valid = 1'b1;
    end
    chk("rst_never_valid", 64'(saw_valid), 64'(0));
    chk("rst_idle", 64'(bus.IN_READY), 64'(1));

    run_op("after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
